digit_scan_driver: RTL and testbench

Parametrised multiplexed-display scan driver for the clock design. It generalises the fixed 2-to-4 one-hot digit select into an N-digit time-multiplexed scanner with a programmable dwell period, an inter-digit blanking gap, per-digit blank masking and frame-coherent snapshotting of the digit values. It sits between the timekeeping/BCD logic and the seven-segment decoder and common-pin drivers.

---
 rtl/display_pkg.sv | 23 ++
 rtl/onehot_decoder.sv | 23 ++
 rtl/digit_scan_driver.sv | 184 ++++++++++++++++++
 tb/tb_digit_scan_driver.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Shared definitions for the multiplexed display path: scan FSM states,
// default digit width and a ceiling-log2 helper for index widths.
package display_pkg;

    localparam int DEFAULT_VAL_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SHOW = 2'd1,
        GAP  = 2'd2
    } scan_state_t;

    // Bits needed to index 'value' items; never less than one bit.
    function automatic int clog2(input int value);
        int width;
        width = 1;
        while ((1 << width) < value) begin
            width = width + 1;
        end
        return width;
    endfunction

endpackage

// File: rtl/onehot_decoder.sv
// Binary index to one-hot decoder with an enable that forces all-zero.
module onehot_decoder
    import display_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = clog2(N)
) (
    input  logic [IW-1:0] index,
    input  logic          en,
    output logic [N-1:0]  onehot
);

    // Exactly one bit set for an in-range index when enabled, otherwise none.
    always_comb begin
        onehot = '0;
        for (int k = 0; k < N; k++) begin
            if (en && (int'(index) == k)) begin
                onehot[k] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/digit_scan_driver.sv
// N-digit time-multiplexed display scanner. Each digit is lit for a
// programmable dwell, followed by an optional all-off gap. Digit values and
// blank bits are snapshotted once per frame so a frame is always coherent.
// All outputs are registered views of the scan state one cycle earlier.
module digit_scan_driver
    import display_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int VAL_W      = DEFAULT_VAL_W,
    parameter int DIV_W      = 16,
    parameter int GAP_CYCLES = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         enable,
    input  logic [DIV_W-1:0]             period,
    input  logic [NUM_DIGITS*VAL_W-1:0]  digits_in,
    input  logic [NUM_DIGITS-1:0]        blank_mask,
    output logic [NUM_DIGITS-1:0]        digit_sel,
    output logic [VAL_W-1:0]             digit_val,
    output logic [clog2(NUM_DIGITS)-1:0] scan_idx,
    output logic                         frame_done
);

    localparam int               IDX_W    = clog2(NUM_DIGITS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);
    localparam logic [DIV_W-1:0] GAP_LAST = DIV_W'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);
    localparam bit               HAS_GAP  = (GAP_CYCLES > 0);

    scan_state_t                 state;
    scan_state_t                 next_state;
    logic [IDX_W-1:0]            idx;
    logic [IDX_W-1:0]            next_idx;
    logic [DIV_W-1:0]            count;
    logic [DIV_W-1:0]            next_count;
    logic [NUM_DIGITS*VAL_W-1:0] snap_vals;
    logic [NUM_DIGITS-1:0]       snap_blank;
    logic                        load_snap;
    logic                        wrap;
    logic                        wrap_q;
    logic                        advance;
    logic [DIV_W-1:0]            dwell_last;
    logic                        show_end;
    logic                        gap_end;
    logic                        lit;
    logic [NUM_DIGITS-1:0]       sel_decoded;
    logic [VAL_W-1:0]            cur_val;
    logic [VAL_W-1:0]            next_val;

    // Final count of a dwell, taken live from period; zero behaves like one.
    always_comb begin
        dwell_last = (period == '0) ? '0 : (period - 1'b1);
    end

    // ">=" lets a lowered period terminate an over-long dwell immediately.
    assign show_end = (count >= dwell_last);
    assign gap_end  = (count >= GAP_LAST);

    // Snapshot value of the current slot and whether it is actually driven.
    assign cur_val = snap_vals[idx*VAL_W +: VAL_W];
    assign lit     = (state == SHOW) && !snap_blank[idx];

    onehot_decoder #(
        .N  (NUM_DIGITS),
        .IW (IDX_W)
    ) u_sel_decoder (
        .index  (idx),
        .en     (lit),
        .onehot (sel_decoded)
    );

    // Next-state logic: dwell/gap timing, slot advance, wrap and snapshot load.
    always_comb begin
        next_state = state;
        next_idx   = idx;
        next_count = count;
        load_snap  = 1'b0;
        wrap       = 1'b0;
        advance    = 1'b0;

        if (!enable) begin
            next_state = IDLE;
            next_idx   = '0;
            next_count = '0;
        end else begin
            case (state)
                IDLE: begin
                    next_state = SHOW;
                    next_idx   = '0;
                    next_count = '0;
                    load_snap  = 1'b1;
                end
                SHOW: begin
                    if (show_end) begin
                        next_count = '0;
                        if (HAS_GAP) begin
                            next_state = GAP;
                        end else begin
                            advance = 1'b1;
                        end
                    end else begin
                        next_count = count + 1'b1;
                    end
                end
                GAP: begin
                    if (gap_end) begin
                        next_count = '0;
                        advance    = 1'b1;
                    end else begin
                        next_count = count + 1'b1;
                    end
                end
                default: begin
                    next_state = IDLE;
                    next_idx   = '0;
                    next_count = '0;
                end
            endcase

            if (advance) begin
                next_state = SHOW;
                if (idx == LAST_IDX) begin
                    next_idx  = '0;
                    wrap      = 1'b1;
                    load_snap = 1'b1;
                end else begin
                    next_idx = idx + 1'b1;
                end
            end
        end
    end

    // Value presented next: fresh in SHOW, held through GAP, zero when idle.
    always_comb begin
        next_val = '0;
        case (state)
            SHOW:    next_val = cur_val;
            GAP:     next_val = digit_val;
            default: next_val = '0;
        endcase
    end

    // Scan state register: FSM state, slot index and dwell/gap counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            idx   <= '0;
            count <= '0;
        end else begin
            state <= next_state;
            idx   <= next_idx;
            count <= next_count;
        end
    end

    // Frame snapshot, reloaded only at scan start and at frame wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            snap_vals  <= '0;
            snap_blank <= '0;
        end else if (load_snap) begin
            snap_vals  <= digits_in;
            snap_blank <= blank_mask;
        end
    end

    // Registered outputs; frame_done is delayed so it lines up with digit 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            digit_sel  <= '0;
            digit_val  <= '0;
            scan_idx   <= '0;
            wrap_q     <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            digit_sel  <= sel_decoded;
            digit_val  <= next_val;
            scan_idx   <= idx;
            wrap_q     <= wrap;
            frame_done <= wrap_q;
        end
    end

endmodule

// File: tb/tb_digit_scan_driver.sv
// Self-checking bench for digit_scan_driver. A slot-level behavioural model
// predicts every output each cycle; directed checks pin the model with
// hand-derived values. A second instance covers the zero-period, no-gap build.
module tb_digit_scan_driver;

    localparam int ND = 4;

    typedef struct packed {
        logic        active;
        logic        lit;
        logic        wrapped;
        int          idx;
        int          elapsed;
        logic [15:0] snap;
        logic [3:0]  blank;
    } mstate_t;

    typedef struct packed {
        logic [3:0] sel;
        logic [3:0] val;
        logic [1:0] idx;
        logic       fd;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        enable;
    logic [15:0] period;
    logic [15:0] digits_in;
    logic [3:0]  blank_mask;
    logic [3:0]  digit_sel;
    logic [3:0]  digit_val;
    logic [1:0]  scan_idx;
    logic        frame_done;

    logic        rst0;
    logic        enable0;
    logic [15:0] period0;
    logic [15:0] digits_in0;
    logic [3:0]  blank_mask0;
    logic [3:0]  digit_sel0;
    logic [3:0]  digit_val0;
    logic [1:0]  scan_idx0;
    logic        frame_done0;

    int errors = 0;
    int checks = 0;
    int c      = 0;

    mstate_t ms_main;
    mstate_t ms_zero;
    exp_t    exp_main;
    exp_t    exp_zero;

    digit_scan_driver #(
        .NUM_DIGITS (4),
        .VAL_W      (4),
        .DIV_W      (16),
        .GAP_CYCLES (1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .period     (period),
        .digits_in  (digits_in),
        .blank_mask (blank_mask),
        .digit_sel  (digit_sel),
        .digit_val  (digit_val),
        .scan_idx   (scan_idx),
        .frame_done (frame_done)
    );

    digit_scan_driver #(
        .NUM_DIGITS (4),
        .VAL_W      (4),
        .DIV_W      (16),
        .GAP_CYCLES (0)
    ) dut0 (
        .clk        (clk),
        .rst        (rst0),
        .enable     (enable0),
        .period     (period0),
        .digits_in  (digits_in0),
        .blank_mask (blank_mask0),
        .digit_sel  (digit_sel0),
        .digit_val  (digit_val0),
        .scan_idx   (scan_idx0),
        .frame_done (frame_done0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One step of the slot model: a digit is lit for max(period,1) cycles,
    // dark for gap cycles, then the next digit; wrapping reloads the frame.
    function automatic mstate_t model_step(input mstate_t s, input logic r, input logic en,
                                           input int per, input int gap,
                                           input logic [15:0] din, input logic [3:0] bm);
        mstate_t n;
        int      dur;
        n         = s;
        n.wrapped = 1'b0;
        if (r) begin
            n = '0;
        end else if (!en) begin
            n.active  = 1'b0;
            n.lit     = 1'b0;
            n.idx     = 0;
            n.elapsed = 0;
        end else if (!s.active) begin
            n.active  = 1'b1;
            n.lit     = 1'b1;
            n.idx     = 0;
            n.elapsed = 0;
            n.snap    = din;
            n.blank   = bm;
        end else begin
            dur = s.lit ? ((per < 1) ? 1 : per) : gap;
            if (s.elapsed + 1 < dur) begin
                n.elapsed = s.elapsed + 1;
            end else if (s.lit && gap > 0) begin
                n.lit     = 1'b0;
                n.elapsed = 0;
            end else begin
                n.lit     = 1'b1;
                n.elapsed = 0;
                n.idx     = (s.idx + 1) % ND;
                if (n.idx == 0) begin
                    n.wrapped = 1'b1;
                    n.snap    = din;
                    n.blank   = bm;
                end
            end
        end
        return n;
    endfunction

    // What the display shows for a given slot-model state.
    function automatic exp_t model_view(input mstate_t s);
        exp_t e;
        e = '0;
        if (s.active) begin
            e.sel = (s.lit && !s.blank[s.idx]) ? 4'(1 << s.idx) : 4'd0;
            e.val = s.snap[s.idx*4 +: 4];
            e.idx = 2'(s.idx);
            e.fd  = s.wrapped;
        end
        return e;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks = checks + 1;
        if (actual !== expected) begin
            errors = errors + 1;
            $display("[TB] FAIL %s at t=%0t: got %0h, expected %0h", name, $time, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic en, input logic [15:0] per,
                                 input logic [15:0] din, input logic [3:0] bm);
        rst        = r;
        enable     = en;
        period     = per;
        digits_in  = din;
        blank_mask = bm;
    endtask

    task automatic waitTo(input int target);
        while (c < target) begin
            @(negedge clk);
            c = c + 1;
        end
    endtask

    // Model advance: outputs after an edge reflect the state before it.
    initial begin
        ms_main  = '0;
        ms_zero  = '0;
        exp_main = '0;
        exp_zero = '0;
        forever begin
            @(posedge clk);
            exp_main = rst  ? exp_t'('0) : model_view(ms_main);
            exp_zero = rst0 ? exp_t'('0) : model_view(ms_zero);
            ms_main  = model_step(ms_main, rst, enable, int'(period), 1, digits_in, blank_mask);
            ms_zero  = model_step(ms_zero, rst0, enable0, int'(period0), 0, digits_in0, blank_mask0);
        end
    end

    // Per-cycle comparison of both instances against the model.
    initial begin
        forever begin
            @(negedge clk);
            checkOutput("model.sel",   32'(digit_sel),   32'(exp_main.sel));
            checkOutput("model.val",   32'(digit_val),   32'(exp_main.val));
            checkOutput("model.idx",   32'(scan_idx),    32'(exp_main.idx));
            checkOutput("model.fd",    32'(frame_done),  32'(exp_main.fd));
            checkOutput("model0.sel",  32'(digit_sel0),  32'(exp_zero.sel));
            checkOutput("model0.val",  32'(digit_val0),  32'(exp_zero.val));
            checkOutput("model0.idx",  32'(scan_idx0),   32'(exp_zero.idx));
            checkOutput("model0.fd",   32'(frame_done0), 32'(exp_zero.fd));
        end
    end

    // Directed scenario with hand-derived expectations.
    initial begin
        int       exp_sel_seq [16] = '{1, 1, 1, 0, 2, 2, 2, 0, 4, 4, 4, 0, 8, 8, 8, 0};
        int       exp_val_seq [16] = '{1, 1, 1, 1, 2, 2, 2, 2, 3, 3, 3, 3, 4, 4, 4, 4};
        int       exp_sel0_seq [8] = '{1, 2, 4, 8, 1, 2, 4, 8};
        int       exp_fd0_seq  [8] = '{0, 0, 0, 0, 1, 0, 0, 0};
        logic [3:0] cap_sel  [16];
        logic [3:0] cap_val  [16];
        logic [3:0] cap_sel0 [8];
        logic       cap_fd0  [8];
        int       pulses;

        applyStimulus(1'b1, 1'b0, 16'd3, 16'h4321, 4'b0000);
        rst0        = 1'b1;
        enable0     = 1'b0;
        period0     = 16'd0;
        digits_in0  = 16'h4321;
        blank_mask0 = 4'b0000;
        repeat (3) @(negedge clk);
        checkOutput("reset.sel", 32'(digit_sel),  32'h0);
        checkOutput("reset.val", 32'(digit_val),  32'h0);
        checkOutput("reset.idx", 32'(scan_idx),   32'h0);
        checkOutput("reset.fd",  32'(frame_done), 32'h0);

        applyStimulus(1'b0, 1'b1, 16'd3, 16'h4321, 4'b0000);
        rst0    = 1'b0;
        enable0 = 1'b1;
        @(negedge clk);
        checkOutput("start.latency_sel", 32'(digit_sel), 32'h0);
        @(negedge clk);
        c = 0;

        for (int i = 0; i < 16; i++) begin
            if (i > 0) waitTo(i);
            cap_sel[i] = digit_sel;
            cap_val[i] = digit_val;
            if (i < 8) begin
                cap_sel0[i] = digit_sel0;
                cap_fd0[i]  = frame_done0;
            end
        end
        for (int i = 0; i < 16; i++) begin
            checkOutput("scan.sel_seq", 32'(cap_sel[i]), 32'(exp_sel_seq[i]));
            checkOutput("scan.val_seq", 32'(cap_val[i]), 32'(exp_val_seq[i]));
        end
        for (int i = 0; i < 8; i++) begin
            checkOutput("nogap.sel_seq", 32'(cap_sel0[i]), 32'(exp_sel0_seq[i]));
            checkOutput("nogap.fd_seq",  32'(cap_fd0[i]),  32'(exp_fd0_seq[i]));
        end

        waitTo(16);
        checkOutput("wrap.sel", 32'(digit_sel),  32'h1);
        checkOutput("wrap.fd",  32'(frame_done), 32'h1);

        pulses = 0;
        for (int i = 0; i < 32; i++) begin
            waitTo(c + 1);
            if (frame_done) pulses = pulses + 1;
        end
        checkOutput("frame.pulses_32", 32'(pulses), 32'd2);

        waitTo(53);
        applyStimulus(1'b0, 1'b1, 16'd3, 16'h9999, 4'b0000);
        waitTo(56);
        checkOutput("snap.d2_sel", 32'(digit_sel), 32'h4);
        checkOutput("snap.d2_val", 32'(digit_val), 32'h3);
        waitTo(60);
        checkOutput("snap.d3_val", 32'(digit_val), 32'h4);
        waitTo(64);
        checkOutput("snap.next_val", 32'(digit_val),  32'h9);
        checkOutput("snap.next_fd",  32'(frame_done), 32'h1);
        waitTo(68);
        checkOutput("snap.next_d1", 32'(digit_val), 32'h9);
        applyStimulus(1'b0, 1'b1, 16'd3, 16'h4321, 4'b0100);

        waitTo(84);
        checkOutput("blank.d1_sel", 32'(digit_sel), 32'h2);
        waitTo(88);
        checkOutput("blank.d2_sel", 32'(digit_sel), 32'h0);
        checkOutput("blank.d2_val", 32'(digit_val), 32'h3);
        checkOutput("blank.d2_idx", 32'(scan_idx),  32'h2);
        waitTo(92);
        checkOutput("blank.d3_sel", 32'(digit_sel), 32'h8);
        waitTo(96);
        checkOutput("blank.len_fd", 32'(frame_done), 32'h1);
        applyStimulus(1'b0, 1'b1, 16'd3, 16'h4321, 4'b0000);
        waitTo(104);
        checkOutput("blank.coherent_sel", 32'(digit_sel), 32'h0);

        waitTo(121);
        applyStimulus(1'b0, 1'b0, 16'd3, 16'h4321, 4'b0000);
        waitTo(122);
        checkOutput("disable.lag_sel", 32'(digit_sel), 32'h4);
        waitTo(123);
        checkOutput("disable.sel", 32'(digit_sel), 32'h0);
        checkOutput("disable.idx", 32'(scan_idx),  32'h0);
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            if (frame_done) pulses = pulses + 1;
            waitTo(c + 1);
        end
        checkOutput("disable.no_fd", 32'(pulses), 32'd0);

        waitTo(130);
        applyStimulus(1'b0, 1'b1, 16'd3, 16'h4321, 4'b0000);
        waitTo(132);
        checkOutput("restart.sel", 32'(digit_sel),  32'h1);
        checkOutput("restart.val", 32'(digit_val),  32'h1);
        checkOutput("restart.fd",  32'(frame_done), 32'h0);

        waitTo(134);
        applyStimulus(1'b1, 1'b1, 16'd3, 16'h4321, 4'b0000);
        waitTo(135);
        checkOutput("gap_rst.sel", 32'(digit_sel), 32'h0);
        checkOutput("gap_rst.val", 32'(digit_val), 32'h0);
        checkOutput("gap_rst.idx", 32'(scan_idx),  32'h0);
        applyStimulus(1'b0, 1'b1, 16'd10, 16'h4321, 4'b0000);

        waitTo(137);
        checkOutput("period.first_sel", 32'(digit_sel), 32'h1);
        waitTo(141);
        applyStimulus(1'b0, 1'b1, 16'd2, 16'h4321, 4'b0000);
        waitTo(142);
        checkOutput("period.last_lit", 32'(digit_sel), 32'h1);
        waitTo(143);
        checkOutput("period.cut_gap", 32'(digit_sel), 32'h0);
        waitTo(144);
        checkOutput("period.d1_a", 32'(digit_sel), 32'h2);
        waitTo(145);
        checkOutput("period.d1_b", 32'(digit_sel), 32'h2);
        waitTo(146);
        checkOutput("period.d1_gap", 32'(digit_sel), 32'h0);
        waitTo(147);
        checkOutput("period.d2", 32'(digit_sel), 32'h4);

        waitTo(160);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
